vector_dot_engine: RTL and testbench

//   Reads two equal-length vectors from a pair of block_ram instances (A and B), multiplies elements pairwise
//   and accumulates a signed dot product. Sits directly downstream of the block_rams: it drives their addr

---
 rtl/vector_dot_engine_if.sv | 39 +++
 rtl/vector_dot_engine.sv | 120 ++++++++++++
 tb/tb_vector_dot_engine.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vector_dot_engine_if.sv
// vector_dot_engine_if
//   Groups the dot-product engine's run-control, RAM read-port and result
//   handshake signals.
//   slave  : the engine's view (drives addresses, busy and the result).
//   master : the surrounding logic's view (drives start/length, RAM data and
//            result_ready).
//   Ports carried:
//     start, length          run request and element count
//     a_addr, b_addr         read addresses to RAM A / RAM B
//     a_data, b_data         RAM data_out, one cycle after the address
//     busy                   engine is not idle
//     result, result_valid   signed dot product and its valid flag
//     result_ready           downstream accepts the result
interface vector_dot_engine_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 24,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH:0]   length;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  busy;
    logic [ACC_WIDTH-1:0]  result;
    logic                  result_valid;
    logic                  result_ready;

    modport master (
        output start, length, a_data, b_data, result_ready,
        input  a_addr, b_addr, busy, result, result_valid
    );

    modport slave (
        input  start, length, a_data, b_data, result_ready,
        output a_addr, b_addr, busy, result, result_valid
    );
endinterface

// File: rtl/vector_dot_engine.sv
// vector_dot_engine
//   Walks two block RAMs in lockstep, multiplies paired elements and
//   accumulates a signed dot product, then offers it downstream over a
//   valid/ready handshake.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low
//     bus    vector_dot_engine_if.slave (start/length, RAM addr/data,
//            busy, result/result_valid/result_ready)
//
//   state  | meaning
//   IDLE   | waiting for start; addresses held at 0
//   FETCH  | presenting addresses 0..L-1, one per cycle
//   DRAIN  | letting the read/multiply/accumulate pipeline empty
//   DONE   | result valid, waiting for result_ready
module vector_dot_engine #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 24,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input logic               clk,
    input logic               reset,
    vector_dot_engine_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    state_t                         state_q, state_d;
    logic   [ADDR_WIDTH:0]          len_q;
    logic   [ADDR_WIDTH:0]          len_clamped;
    logic   [ADDR_WIDTH-1:0]        idx_q;
    logic   [1:0]                   drain_q;
    logic                           data_v_q;
    logic                           prod_v_q;
    logic signed [2*DATA_WIDTH-1:0] prod_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic                           start_acc;
    logic                           last_fetch;

    assign len_clamped = (bus.length > DEPTH) ? DEPTH : bus.length;
    assign start_acc   = (state_q == S_IDLE) && bus.start;
    assign last_fetch  = ({1'b0, idx_q} == (len_q - (ADDR_WIDTH+1)'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-length run still passes through DRAIN (with an empty drain
    // count) so the result appears one cycle after the start edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = (len_clamped == '0) ? S_DRAIN : S_FETCH;
            S_FETCH: if (last_fetch) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == 2'd0) state_d = S_DONE;
            S_DONE:  if (bus.result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q != S_IDLE);
        bus.result_valid = (state_q == S_DONE);
        bus.a_addr       = '0;
        bus.b_addr       = '0;
        if (state_q == S_FETCH) begin
            bus.a_addr = idx_q;
            bus.b_addr = idx_q;
        end
        bus.result = acc_q;
    end

    // Pipeline: address in cycle k -> RAM data valid in k+1 (data_v_q) ->
    // product registered at end of k+1 (prod_v_q) -> accumulated at end of k+2.
    // The drain count of 2 covers those two stages plus the cycle into DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q    <= '0;
            idx_q    <= '0;
            drain_q  <= '0;
            data_v_q <= 1'b0;
            prod_v_q <= 1'b0;
            prod_q   <= '0;
            acc_q    <= '0;
        end else begin
            data_v_q <= (state_q == S_FETCH);
            prod_v_q <= data_v_q;
            prod_q   <= (2*DATA_WIDTH)'($signed(bus.a_data)) *
                        (2*DATA_WIDTH)'($signed(bus.b_data));

            if (start_acc) begin
                acc_q <= '0;
            end else if (prod_v_q) begin
                acc_q <= acc_q + ACC_WIDTH'(prod_q);
            end

            if (start_acc) begin
                len_q <= len_clamped;
                idx_q <= '0;
            end else if (state_q == S_FETCH) begin
                idx_q <= last_fetch ? '0 : idx_q + ADDR_WIDTH'(1);
            end

            if (start_acc) begin
                drain_q <= 2'd0;
            end else if ((state_q == S_FETCH) && last_fetch) begin
                drain_q <= 2'd2;
            end else if ((state_q == S_DRAIN) && (drain_q != 2'd0)) begin
                drain_q <= drain_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_vector_dot_engine.sv
// tb_vector_dot_engine
//   Drives the engine with directed and random vectors held in a behavioural
//   pair of synchronous-read RAMs. Expected results are queued when a run is
//   launched and compared by an independent monitor at each handshake.
module tb_vector_dot_engine;

    localparam int AW  = 4;
    localparam int DW  = 24;
    localparam int ACW = 2*DW+AW;
    localparam int DEP = 2**AW;

    logic clk;
    logic reset;

    vector_dot_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACW)) bus ();

    vector_dot_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0]  mem_a [DEP];
    logic [DW-1:0]  mem_b [DEP];
    logic [ACW-1:0] exp_q [$];
    int             errors = 0;
    int             checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.a_data <= mem_a[bus.a_addr];
        bus.b_data <= mem_b[bus.b_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: valid&&ready seen mid-cycle means the handshake happens at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", bus.result);
                end else begin
                    chk("result", 64'(bus.result), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    function automatic logic [ACW-1:0] ref_dot(input int len);
        longint sum;
        int     n;
        n   = (len > DEP) ? DEP : len;
        sum = 0;
        for (int i = 0; i < n; i++)
            sum += longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
        return sum[ACW-1:0];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEP; i++) begin
            mem_a[i] = DW'($urandom());
            mem_b[i] = DW'($urandom());
        end
    endtask

    // Launch a run and follow it until result_valid, checking addresses,
    // busy and latency on the way. Does not wait for the handshake.
    task automatic do_run(input int len, input logic [ACW-1:0] expv);
        int  n;
        int  l;
        bit  seen;
        l = (len > DEP) ? DEP : len;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.length = (AW+1)'(len);
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n <= 40) begin
            chk("a_addr", 64'(bus.a_addr), 64'((n < l) ? n : 0));
            chk("b_addr", 64'(bus.b_addr), 64'((n < l) ? n : 0));
            chk("busy_run", 64'(bus.busy), 64'd1);
            if (bus.result_valid === 1'b1) begin
                seen = 1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("latency", 64'(n), 64'((l == 0) ? 1 : l + 3));
    endtask

    task automatic finish_hs();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.busy === 1'b1 && n < 10);
        chk("busy_after_hs", 64'(bus.busy), 64'd0);
        chk("valid_after_hs", 64'(bus.result_valid), 64'd0);
    endtask

    task automatic load_case1();
        fill_random();
        mem_a[0] = 24'd1; mem_a[1] = 24'd2; mem_a[2] = 24'd3; mem_a[3] = 24'd4;
        mem_b[0] = 24'd5; mem_b[1] = 24'd6; mem_b[2] = 24'd7; mem_b[3] = 24'd8;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.length       = '0;
        bus.result_ready = 1'b1;
        fill_random();
        #3;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_addr", 64'(bus.a_addr), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic vector
        load_case1();
        do_run(4, 52'd70);
        finish_hs();

        // Signed elements
        fill_random();
        mem_a[0] = 24'hFFFFFF; mem_a[1] = 24'd2;
        mem_b[0] = 24'd3;      mem_b[1] = 24'hFFFFFC;
        do_run(2, 52'hF_FFFF_FFFF_FFF5);
        finish_hs();

        // Full depth of most-negative values, then an over-long length
        for (int i = 0; i < DEP; i++) begin
            mem_a[i] = 24'h800000;
            mem_b[i] = 24'h800000;
        end
        do_run(16, 52'h4_0000_0000_0000);
        finish_hs();
        do_run(20, 52'h4_0000_0000_0000);
        finish_hs();

        // Zero length
        fill_random();
        do_run(0, 52'd0);
        finish_hs();

        // Backpressure, with start pulses during DONE and at the handshake edge
        load_case1();
        bus.result_ready = 1'b0;
        do_run(4, 52'd70);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus.start = 1'b1;
            if (k == 3) bus.start = 1'b0;
            chk("bp_result", 64'(bus.result), 64'd70);
            chk("bp_valid", 64'(bus.result_valid), 64'd1);
            chk("bp_busy", 64'(bus.busy), 64'd1);
        end
        bus.start        = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("hs_busy", 64'(bus.busy), 64'd0);
        chk("hs_valid", 64'(bus.result_valid), 64'd0);
        chk("hs_result_kept", 64'(bus.result), 64'd70);
        @(posedge clk);
        #1;
        chk("hs_start_ignored", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of a fetch, then a clean rerun
        load_case1();
        @(negedge clk);
        bus.length = 5'd4;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_addr", 64'(bus.a_addr), 64'd3);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_addr", 64'(bus.a_addr), 64'd0);
        chk("mid_rst_valid", 64'(bus.result_valid), 64'd0);
        chk("mid_rst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        do_run(4, 52'd70);
        finish_hs();

        // Random vectors against the reference model
        for (int r = 0; r < 12; r++) begin
            fill_random();
            len = int'($urandom_range(0, 20));
            do_run(len, ref_dot(len));
            finish_hs();
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
